tl45_scoreboard: RTL and testbench
==================================

TL45_SCOREBOARD -- requirements
Module: tl45_scoreboard

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state resets immediately on i_reset_n low and is otherwise clocked on the rising edge of i_clk.
REQ-002 SHALL have port i_clk  input  1  system clock.
REQ-003 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_flush  input  1  squash all in-flight writes (branch or exception).
REQ-005 SHALL have port i_dec_valid  input  1  decode stage holds an instruction.
REQ-006 SHALL have ports i_dec_dr, i_dec_sr1, i_dec_sr2  input  4 each  decoded destination and source registers.
REQ-007 SHALL have port i_dec_wr  input  1  instruction writes dr.
REQ-008 SHALL have port i_dec_rd2  input  1  instruction reads sr2 (register form).
REQ-009 SHALL have port i_ex_stall  input  1  execute stage cannot accept.
REQ-010 SHALL have ports i_wb_valid (1) and i_wb_dr (4)  input  writeback retires a write to wb_dr.
REQ-011 SHALL have port o_issue  output  1  instruction advances to execute this cycle.
REQ-012 SHALL have port o_pipe_stall  output  1  hold decode.
REQ-013 SHALL have port o_busy  output  1  any register write pending.
REQ-014 SHALL have port o_sb_err  output  1  sticky underflow error.
REQ-015 SHALL have port o_stall_cycles  output  16  hazard-stall counter (see Configuration).

Function
REQ-016 SHALL keep a 2-bit pending-write counter for each of r1..r15; r0 SHALL never be pending, and reads or writes of r0 SHALL never cause a hazard.
REQ-017 SHALL assert hazard when pend[sr1]!=0, or when i_dec_rd2 is high and pend[sr2]!=0, or when i_dec_wr is high and pend[dr]==3 (saturation).
REQ-018 SHALL drive o_issue combinationally, at zero latency, as i_dec_valid & !hazard & !i_ex_stall & !i_flush & (state==RUN).
REQ-019 SHALL drive o_pipe_stall combinationally as i_dec_valid & !o_issue.
REQ-020 SHALL compute hazard from registered counters only, with no bypass: a retire at edge N unblocks a dependent instruction in cycle N+1 at the earliest.
REQ-021 SHALL, on o_issue with i_dec_wr and dr!=0, increment pend[dr] at the next edge.
REQ-022 SHALL, on i_wb_valid with wb_dr!=0 in RUN, decrement pend[wb_dr] at the next edge.
REQ-023 SHALL leave pend unchanged when an issue and a retire target the same register in the same cycle.
REQ-024 SHALL, on a retire to a counter already at 0, leave the counter at 0 and set o_sb_err, which SHALL hold until reset.
REQ-025 SHALL implement a two-state FSM with states RUN and FLUSH: i_flush in RUN SHALL clear all counters at the edge and enter FLUSH.
REQ-026 SHALL hold FLUSH for exactly one cycle, return to RUN, force o_issue to 0, and ignore retires in FLUSH without raising an error.
REQ-027 SHALL, on i_flush asserted in FLUSH, clear the counters again and remain in FLUSH.
REQ-028 SHALL drive o_busy combinationally as OR over all pend!=0.

Reset
REQ-029 SHALL, on i_reset_n low, immediately set all counters to 0, state to RUN, o_sb_err to 0 and o_stall_cycles to 0.
REQ-030 SHALL, while i_reset_n is low, hold o_issue=0, o_pipe_stall=i_dec_valid and o_busy=0.
REQ-031 SHALL, on reset assertion mid-operation, discard all pending entries, with no error raised by later orphan retires until the first post-reset retire to a zero counter.

Configuration
REQ-032 SHALL, when TL45_HAZARD_STATS_EN is defined, increment o_stall_cycles by 1 each cycle o_pipe_stall is high due to hazard (not i_ex_stall or FLUSH), saturating at 16'hFFFF and reset only by i_reset_n.
REQ-033 SHALL, when TL45_HAZARD_STATS_EN is undefined, tie o_stall_cycles to 0 and instantiate no counter logic.

Verification
REQ-034 SHALL cover RAW: issue ADD dr=3, then next cycle sr1=3 -> o_pipe_stall=1 until the cycle after i_wb_valid with wb_dr=3, then o_issue=1.
REQ-035 SHALL cover saturation: three issues with dr=5 and no retire, fourth with dr=5 -> stalled; one retire of r5 -> issues next cycle.
REQ-036 SHALL cover simultaneous events: issue dr=7 and retire wb_dr=7 in the same cycle with pend[7]=1 -> pend[7] stays 1 and o_busy=1.
REQ-037 SHALL cover flush: pend[2]=2, i_flush -> next cycle FLUSH with o_issue=0 and o_busy=0; a retire of r2 there -> o_sb_err stays 0; RUN on the following cycle.
REQ-038 SHALL cover underflow and r0: a retire of r4 with pend[4]=0 -> o_sb_err=1 sticky; an instruction with sr1=0 and dr=0 -> never stalls, never sets busy.
REQ-039 SHALL cover stats (macro defined): 10 hazard-stall cycles plus 4 i_ex_stall cycles -> o_stall_cycles=10; async reset mid-stall -> 0 immediately.

Source files
------------

// File: rtl/tl45_scoreboard.sv
// tl45_scoreboard: register write scoreboard for the TL45 pipeline.
//
// Each register r1..r15 has a 2-bit counter of in-flight writes. Decode is
// held while a source is pending or the destination counter is saturated.
// A flush squashes every in-flight write and blocks issue for one cycle.
//
// Optional feature: define TL45_HAZARD_STATS_EN to enable the hazard-stall
// cycle counter on o_stall_cycles. Without it the port is tied to zero.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_flush                 squash all in-flight writes
//   i_dec_valid             decode holds an instruction
//   i_dec_dr/sr1/sr2        decoded destination and source registers
//   i_dec_wr, i_dec_rd2     instruction writes dr / reads sr2
//   i_ex_stall              execute cannot accept
//   i_wb_valid, i_wb_dr     writeback retires a write to wb_dr
//   o_issue                 instruction advances this cycle (combinational)
//   o_pipe_stall            hold decode (combinational)
//   o_busy                  any write pending (combinational)
//   o_sb_err                sticky underflow error
//   o_stall_cycles          hazard-stall cycle counter
module tl45_scoreboard (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic        i_dec_valid,
    input  logic [3:0]  i_dec_dr,
    input  logic [3:0]  i_dec_sr1,
    input  logic [3:0]  i_dec_sr2,
    input  logic        i_dec_wr,
    input  logic        i_dec_rd2,
    input  logic        i_ex_stall,
    input  logic        i_wb_valid,
    input  logic [3:0]  i_wb_dr,
    output logic        o_issue,
    output logic        o_pipe_stall,
    output logic        o_busy,
    output logic        o_sb_err,
    output logic [15:0] o_stall_cycles
);

    localparam int unsigned NREG = 16;
    localparam int unsigned PW   = 2;
    localparam int unsigned SW   = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pend_q [NREG];
    logic [PW-1:0] pend_d [NREG];
    logic          sb_err_q, sb_err_d;
    logic          hazard;
    logic          inc, dec;

    // Hazard from registered counters only; r0 is never pending.
    always_comb begin
        hazard = 1'b0;
        if (i_dec_sr1 != 4'd0 && pend_q[i_dec_sr1] != 2'd0) begin
            hazard = 1'b1;
        end
        if (i_dec_rd2 && i_dec_sr2 != 4'd0 && pend_q[i_dec_sr2] != 2'd0) begin
            hazard = 1'b1;
        end
        if (i_dec_wr && i_dec_dr != 4'd0 && pend_q[i_dec_dr] == 2'd3) begin
            hazard = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: FLUSH lasts one cycle unless flushed again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (i_flush)  state_d = ST_FLUSH;
            ST_FLUSH: if (!i_flush) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs; issue is gated by reset so nothing advances while held.
    always_comb begin
        o_issue      = 1'b0;
        o_pipe_stall = 1'b0;
        o_busy       = 1'b0;
        o_issue      = i_reset_n & i_dec_valid & ~hazard & ~i_ex_stall
                     & ~i_flush & (state_q == ST_RUN);
        o_pipe_stall = i_dec_valid & ~o_issue;
        for (int i = 1; i < NREG; i++) begin
            if (pend_q[i] != 2'd0) begin
                o_busy = 1'b1;
            end
        end
    end

    // Counter and error update.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pend_d[i] = pend_q[i];
        end
        sb_err_d = sb_err_q;
        inc      = o_issue & i_dec_wr & (i_dec_dr != 4'd0);
        dec      = i_wb_valid & (i_wb_dr != 4'd0);
        if (i_flush) begin
            for (int i = 0; i < NREG; i++) begin
                pend_d[i] = '0;
            end
        end else if (state_q == ST_RUN) begin
            // Issue and retire to the same register cancel out.
            if (!(inc && dec && i_dec_dr == i_wb_dr)) begin
                if (inc) begin
                    pend_d[i_dec_dr] = pend_q[i_dec_dr] + 2'd1;
                end
                if (dec) begin
                    if (pend_q[i_wb_dr] == 2'd0) begin
                        sb_err_d = 1'b1;
                    end else begin
                        pend_d[i_wb_dr] = pend_q[i_wb_dr] - 2'd1;
                    end
                end
            end
        end
        pend_d[0] = '0;
    end

    // Counter and error registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= pend_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign o_sb_err = sb_err_q;

`ifdef TL45_HAZARD_STATS_EN
    logic [SW-1:0] stall_cycles_q, stall_cycles_d;

    // Count only stalls caused by a hazard, never by execute back-pressure or flush.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (i_dec_valid && hazard && !i_ex_stall && !i_flush
            && state_q == ST_RUN && stall_cycles_q != {SW{1'b1}}) begin
            stall_cycles_d = stall_cycles_q + SW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign o_stall_cycles = stall_cycles_q;
`else
    assign o_stall_cycles = SW'(0);
`endif

endmodule

// File: tb/tb_tl45_scoreboard.sv
// tb_tl45_scoreboard: directed vector table plus hand-written multi-cycle
// sequences for tl45_scoreboard. Inputs change on the falling edge and the
// combinational outputs are sampled 1 ns later, well before the rising edge.
module tb_tl45_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dv;
    logic [3:0]  dr, sr1, sr2;
    logic        wr, rd2, xs, wbv;
    logic [3:0]  wbdr;
    logic        issue, pstall, busy, err;
    logic [15:0] scyc;

    int nchk;
    int nerr;

    tl45_scoreboard dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_flush        (flush),
        .i_dec_valid    (dv),
        .i_dec_dr       (dr),
        .i_dec_sr1      (sr1),
        .i_dec_sr2      (sr2),
        .i_dec_wr       (wr),
        .i_dec_rd2      (rd2),
        .i_ex_stall     (xs),
        .i_wb_valid     (wbv),
        .i_wb_dr        (wbdr),
        .o_issue        (issue),
        .o_pipe_stall   (pstall),
        .o_busy         (busy),
        .o_sb_err       (err),
        .o_stall_cycles (scyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic       dv;
        logic [3:0] dr;
        logic [3:0] sr1;
        logic [3:0] sr2;
        logic       wr;
        logic       rd2;
        logic       xs;
        logic       wbv;
        logic [3:0] wbdr;
        logic       e_issue;
        logic       e_stall;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    localparam int NV = 35;
    vec_t vt [NV];

`ifdef TL45_HAZARD_STATS_EN
    localparam logic [15:0] TABLE_STALLS = 16'd5;
    localparam logic [15:0] SEQ_STALLS   = 16'd10;
`else
    localparam logic [15:0] TABLE_STALLS = 16'd0;
    localparam logic [15:0] SEQ_STALLS   = 16'd0;
`endif

    function automatic vec_t mk(input logic f, input logic v, input logic [3:0] d,
                                input logic [3:0] s1, input logic [3:0] s2,
                                input logic w, input logic r2, input logic x,
                                input logic bv, input logic [3:0] bd,
                                input logic ei, input logic es, input logic eb,
                                input logic ee);
        vec_t t;
        t.flush = f;  t.dv = v;    t.dr = d;    t.sr1 = s1;  t.sr2 = s2;
        t.wr = w;     t.rd2 = r2;  t.xs = x;    t.wbv = bv;  t.wbdr = bd;
        t.e_issue = ei; t.e_stall = es; t.e_busy = eb; t.e_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [3:0] d,
                         input logic [3:0] s1, input logic [3:0] s2, input logic w,
                         input logic r2, input logic x, input logic bv,
                         input logic [3:0] bd);
        flush = f; dv = v; dr = d; sr1 = s1; sr2 = s2;
        wr = w; rd2 = r2; xs = x; wbv = bv; wbdr = bd;
    endtask

    task automatic idle();
        drive(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0);
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        //            fl dv dr     sr1    sr2    wr r2 xs wv wbdr   iss stl bsy err
        // RAW on r3
        vt[0]  = mk(0, 1, 4'd3, 4'd1, 4'd2, 1, 1, 0, 0, 4'd0,  1, 0, 0, 0);
        vt[1]  = mk(0, 1, 4'd4, 4'd3, 4'd0, 1, 0, 0, 0, 4'd0,  0, 1, 1, 0);
        vt[2]  = mk(0, 1, 4'd4, 4'd3, 4'd0, 1, 0, 0, 1, 4'd3,  0, 1, 1, 0);
        vt[3]  = mk(0, 1, 4'd4, 4'd3, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 0, 0);
        vt[4]  = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd4,  0, 0, 1, 0);
        // saturation on r5
        vt[5]  = mk(0, 1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 0, 0);
        vt[6]  = mk(0, 1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 1, 0);
        vt[7]  = mk(0, 1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 1, 0);
        vt[8]  = mk(0, 1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  0, 1, 1, 0);
        vt[9]  = mk(0, 1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 1, 4'd5,  0, 1, 1, 0);
        vt[10] = mk(0, 1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 1, 0);
        vt[11] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd5,  0, 0, 1, 0);
        vt[12] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd5,  0, 0, 1, 0);
        vt[13] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd5,  0, 0, 1, 0);
        vt[14] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0,  0, 0, 0, 0);
        // simultaneous issue and retire on r7
        vt[15] = mk(0, 1, 4'd7, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 0, 0);
        vt[16] = mk(0, 1, 4'd7, 4'd0, 4'd0, 1, 0, 0, 1, 4'd7,  1, 0, 1, 0);
        vt[17] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0,  0, 0, 1, 0);
        vt[18] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd7,  0, 0, 1, 0);
        vt[19] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0,  0, 0, 0, 0);
        // execute back-pressure, then sr2 only matters with rd2
        vt[20] = mk(0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 4'd0,  0, 1, 0, 0);
        vt[21] = mk(0, 1, 4'd8, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 0, 0);
        vt[22] = mk(0, 1, 4'd0, 4'd0, 4'd8, 0, 0, 0, 0, 4'd0,  1, 0, 1, 0);
        vt[23] = mk(0, 1, 4'd0, 4'd0, 4'd8, 0, 1, 0, 0, 4'd0,  0, 1, 1, 0);
        vt[24] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd8,  0, 0, 1, 0);
        vt[25] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0,  0, 0, 0, 0);
        // flush with pend[2]=2, retire ignored in FLUSH
        vt[26] = mk(0, 1, 4'd2, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 0, 0);
        vt[27] = mk(0, 1, 4'd2, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 1, 0);
        vt[28] = mk(1, 1, 4'd2, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  0, 1, 1, 0);
        vt[29] = mk(0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd2,  0, 1, 0, 0);
        vt[30] = mk(0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0,  1, 0, 0, 0);
        // underflow on r4, r0 never pending
        vt[31] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd4,  0, 0, 0, 0);
        vt[32] = mk(0, 1, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 0, 1);
        vt[33] = mk(0, 1, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0,  1, 0, 0, 1);
        vt[34] = mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0,  0, 0, 0, 1);

        // Outputs while reset is held.
        rst_n = 1'b0;
        idle();
        dv = 1'b1;
        #3;
        chk("rst_issue", 32'(issue), 32'd0);
        chk("rst_pstall", 32'(pstall), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_scyc", 32'(scyc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].flush, vt[i].dv, vt[i].dr, vt[i].sr1, vt[i].sr2,
                  vt[i].wr, vt[i].rd2, vt[i].xs, vt[i].wbv, vt[i].wbdr);
            #1;
            chk($sformatf("v%0d_issue", i), 32'(issue), 32'(vt[i].e_issue));
            chk($sformatf("v%0d_pstall", i), 32'(pstall), 32'(vt[i].e_stall));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
        end
        chk("table_scyc", 32'(scyc), 32'(TABLE_STALLS));

        // Reset mid-operation discards pending writes and clears the error.
        @(negedge clk);
        drive(0, 1, 4'd9, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0);
        @(negedge clk);
        #1;
        chk("r9_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_issue", 32'(issue), 32'd0);
        chk("mid_rst_pstall", 32'(pstall), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 4'd0, 4'd9, 4'd0, 0, 0, 0, 0, 4'd0);
        #1;
        chk("post_rst_dep_issue", 32'(issue), 32'd1);

        // Flush while already in FLUSH extends it by one cycle.
        @(negedge clk);
        drive(1, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0);
        #1;
        chk("ff0_issue", 32'(issue), 32'd0);
        @(negedge clk);
        #1;
        chk("ff1_issue", 32'(issue), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("ff2_issue", 32'(issue), 32'd0);
        @(negedge clk);
        #1;
        chk("ff3_issue", 32'(issue), 32'd1);

        // Stall statistics: 10 hazard cycles, 4 execute-stall cycles.
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 4'd3, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0);
        @(negedge clk);
        drive(0, 1, 4'd0, 4'd3, 4'd0, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
        end
        #1;
        chk("stats_hz_stall", 32'(pstall), 32'd1);
        drive(0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
        end
        #1;
        chk("stats_scyc", 32'(scyc), 32'(SEQ_STALLS));
        drive(0, 1, 4'd0, 4'd3, 4'd0, 0, 0, 0, 0, 4'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("stats_rst_scyc", 32'(scyc), 32'd0);
        chk("stats_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
